// File: rtl/imem_pkg.sv
// Shared types and constants for the programmable instruction memory.
package imem_pkg;

  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } imem_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_RANGE    = 2'd2
  } fetch_fault_e;

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
module imem_array #(
  parameter int              DATA_W  = 32,
  parameter int              DEPTH   = 64,
  parameter int              IDX_W   = $clog2(DEPTH),
  parameter logic [DATA_W-1:0] RD_INIT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  // Storage carries no reset; the owner sweeps it after reset instead.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= RD_INIT;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_prog.sv
// Programmable instruction memory: post-reset NOP sweep, streaming load port,
// and byte-addressed fetch with alignment/range fault reporting.
module imem_prog
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic [1:0]        fetch_fault,
  input  logic              prog_start,
  input  logic [IDX_W-1:0]  prog_base,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_last,
  output logic              prog_ready,
  output logic              load_busy,
  output logic              load_done
);

  localparam logic [DATA_W-1:0] NOP      = DATA_W'(IMEM_NOP);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  imem_state_e       state_q, state_d;
  logic [IDX_W-1:0]  clr_ptr, wr_ptr;
  fetch_fault_e      fault_q, fault_d;
  logic              accept, fetch_go;
  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata, rdata;

  assign accept   = (state_q == LOAD) && prog_valid;
  assign fetch_go = (state_q == IDLE) && fetch_en;

  always_ff @(posedge clk) begin
    if (reset) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clr_ptr == LAST_IDX)      state_d = IDLE;
      IDLE:    if (prog_start)               state_d = LOAD;
      LOAD:    if (accept && prog_last)      state_d = IDLE;
      default:                               state_d = CLEAR;
    endcase
  end

  // Pointers and handshake flags
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_ptr   <= '0;
      wr_ptr    <= '0;
      load_done <= 1'b0;
    end else begin
      load_done <= accept && prog_last;
      if (state_q == CLEAR) clr_ptr <= clr_ptr + 1'b1;
      if (state_q == IDLE && prog_start) wr_ptr <= prog_base;
      else if (accept)                   wr_ptr <= wr_ptr + 1'b1;
    end
  end

  assign prog_ready = (state_q == LOAD);
  assign load_busy  = (state_q != IDLE);

  // Write port is owned by the sweep in CLEAR and by the loader in LOAD.
  always_comb begin
    we    = 1'b0;
    waddr = wr_ptr;
    wdata = prog_data;
    if (state_q == CLEAR) begin
      we    = 1'b1;
      waddr = clr_ptr;
      wdata = NOP;
    end else if (accept) begin
      we = 1'b1;
    end
  end

  // Misalignment outranks range.
  always_comb begin
    fault_d = FAULT_NONE;
    if (pc[1:0] != 2'b00)                fault_d = FAULT_MISALIGN;
    else if ((pc >> 2) >= ADDR_W'(DEPTH)) fault_d = FAULT_RANGE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q     <= FAULT_NONE;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= fetch_go;
      if (fetch_go) fault_q <= fault_d;
    end
  end

  imem_array #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .IDX_W   (IDX_W),
    .RD_INIT (NOP)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (fetch_go && fault_d == FAULT_NONE),
    .raddr (pc[IDX_W+1:2]),
    .rdata (rdata)
  );

  // The read register only updates on good fetches; faults mask it to NOP.
  assign instr_out   = (fault_q == FAULT_NONE) ? rdata : NOP;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_imem_prog.sv
// Directed bench for imem_prog with DEPTH=64, DATA_W=32.
module tb_imem_prog;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = 6;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_en;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr_out;
  logic              instr_valid;
  logic [1:0]        fetch_fault;
  logic              prog_start;
  logic [IDX_W-1:0]  prog_base;
  logic              prog_valid;
  logic [DATA_W-1:0] prog_data;
  logic              prog_last;
  logic              prog_ready;
  logic              load_busy;
  logic              load_done;

  int checks = 0;
  int errors = 0;

  imem_prog #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc(pc),
    .instr_out(instr_out), .instr_valid(instr_valid), .fetch_fault(fetch_fault),
    .prog_start(prog_start), .prog_base(prog_base), .prog_valid(prog_valid),
    .prog_data(prog_data), .prog_last(prog_last), .prog_ready(prog_ready),
    .load_busy(load_busy), .load_done(load_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] a,
                       input logic [31:0] exp_instr, input logic [1:0] exp_fault);
    fetch_en = 1'b1;
    pc       = a;
    tick();
    fetch_en = 1'b0;
    chk({tag, ".instr"}, instr_out, exp_instr);
    chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, ".fault"}, {30'd0, fetch_fault}, {30'd0, exp_fault});
  endtask

  task automatic wait_clear(input string tag, output int n, output int done_seen);
    n = 0;
    done_seen = 0;
    while (load_busy === 1'b1 && n < 200) begin
      tick();
      n++;
      if (load_done === 1'b1) done_seen++;
    end
    chk({tag, ".clear_cycles"}, n, DEPTH);
  endtask

  task automatic put(input logic v, input logic [31:0] d, input logic l);
    prog_valid = v;
    prog_data  = d;
    prog_last  = l;
    tick();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
  endtask

  initial begin
    int n, ds;
    reset = 1'b1; fetch_en = 1'b0; pc = '0;
    prog_start = 1'b0; prog_base = '0; prog_valid = 1'b0; prog_data = '0; prog_last = 1'b0;
    tick(); tick();
    chk("rst.instr", instr_out, NOP);
    chk("rst.valid", {31'd0, instr_valid}, 32'd0);
    chk("rst.fault", {30'd0, fetch_fault}, 32'd0);
    chk("rst.ready", {31'd0, prog_ready}, 32'd0);
    chk("rst.busy",  {31'd0, load_busy}, 32'd1);
    chk("rst.done",  {31'd0, load_done}, 32'd0);

    reset = 1'b0;
    wait_clear("boot", n, ds);
    fetch("f0", 32'h0, NOP, 2'd0);
    fetch("fFC", 32'hFC, NOP, 2'd0);

    // Hold after a stall
    tick();
    chk("stall.valid", {31'd0, instr_valid}, 32'd0);
    chk("stall.instr", instr_out, NOP);

    // Two-word load at base 2
    prog_start = 1'b1; prog_base = 6'd2;
    tick();
    prog_start = 1'b0;
    chk("ld.ready", {31'd0, prog_ready}, 32'd1);
    chk("ld.busy",  {31'd0, load_busy}, 32'd1);
    put(1'b1, 32'h0050_0093, 1'b0);
    chk("ld.done_early", {31'd0, load_done}, 32'd0);
    put(1'b1, 32'h0010_8113, 1'b1);
    chk("ld.done", {31'd0, load_done}, 32'd1);
    chk("ld.busy_fall", {31'd0, load_busy}, 32'd0);
    tick();
    chk("ld.done_pulse", {31'd0, load_done}, 32'd0);
    fetch("f8", 32'h8, 32'h0050_0093, 2'd0);
    fetch("fC", 32'hC, 32'h0010_8113, 2'd0);
    fetch("f10", 32'h10, NOP, 2'd0);

    // Faults
    fetch("mis6", 32'h6, NOP, 2'd1);
    fetch("rng100", 32'h100, NOP, 2'd2);
    fetch("mis102", 32'h102, NOP, 2'd1);
    fetch("f8b", 32'h8, 32'h0050_0093, 2'd0);

    // Wrapping load with gaps and a stray last
    prog_start = 1'b1; prog_base = 6'd63;
    tick();
    prog_start = 1'b0;
    put(1'b1, 32'hAAAA_0001, 1'b0);
    put(1'b0, 32'hDEAD_0000, 1'b0);
    put(1'b1, 32'hBBBB_0002, 1'b0);
    put(1'b0, 32'hDEAD_0001, 1'b1);
    chk("wrap.ready_after_stray", {31'd0, prog_ready}, 32'd1);
    put(1'b0, 32'hDEAD_0002, 1'b0);
    put(1'b1, 32'hCCCC_0003, 1'b1);
    chk("wrap.done", {31'd0, load_done}, 32'd1);
    fetch("wFC", 32'hFC, 32'hAAAA_0001, 2'd0);
    fetch("w0", 32'h0, 32'hBBBB_0002, 2'd0);
    fetch("w4", 32'h4, 32'hCCCC_0003, 2'd0);
    fetch("w8", 32'h8, 32'h0050_0093, 2'd0);
    fetch("w10", 32'h10, NOP, 2'd0);

    // Reset mid-load
    prog_start = 1'b1; prog_base = 6'd10;
    tick();
    prog_start = 1'b0;
    put(1'b1, 32'h1234_5678, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr.busy", {31'd0, load_busy}, 32'd1);
    chk("rr.ready", {31'd0, prog_ready}, 32'd0);
    wait_clear("rr", n, ds);
    chk("rr.no_done", ds, 0);
    fetch("rr28", 32'h28, NOP, 2'd0);
    fetch("rr0", 32'h0, NOP, 2'd0);
    fetch("rrFC", 32'hFC, NOP, 2'd0);
    fetch("rr8", 32'h8, NOP, 2'd0);

    // fetch_en held through a load
    fetch_en = 1'b1; pc = 32'h50;
    prog_start = 1'b1; prog_base = 6'd20;
    tick();
    prog_start = 1'b0;
    chk("fl.start_valid", {31'd0, instr_valid}, 32'd1);
    prog_valid = 1'b0;
    tick();
    chk("fl.gap_valid", {31'd0, instr_valid}, 32'd0);
    prog_valid = 1'b1; prog_data = 32'h0FED_CBA9; prog_last = 1'b1;
    tick();
    prog_valid = 1'b0; prog_last = 1'b0;
    chk("fl.last_valid", {31'd0, instr_valid}, 32'd0);
    chk("fl.done", {31'd0, load_done}, 32'd1);
    tick();
    chk("fl.idle_valid", {31'd0, instr_valid}, 32'd1);
    chk("fl.idle_instr", instr_out, 32'h0FED_CBA9);
    fetch_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_prog.md
# imem_prog

Parametrised, programmable instruction memory for the single-cycle RISC-V core. It generalises the fixed 64×32 fetch store with configurable depth and width, byte-addressed PC fetch with alignment/range checking, and a sequential post-reset NOP-fill sweep. It also provides a valid/ready load port so a boot loader (UART/JTAG bridge) can stream a program in at run time. It sits between the PC register and the decoder.

## Interface
Parameters:
- `DATA_W`, 32, instruction width in bits
- `DEPTH`, 64, number of instruction words; power of two, ≥ 4
- `ADDR_W`, 32, PC width in bits; byte address
- `IDX_W`, `$clog2(DEPTH)`, derived word-index width; not overridden

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `fetch_en`  in  1  request a fetch at `pc` this cycle
- `pc`  in  `ADDR_W`  byte address of the instruction
- `instr_out`  out  `DATA_W`  registered instruction
- `instr_valid`  out  1  `instr_out` holds the result of last cycle's fetch
- `fetch_fault`  out  2  cause: 0 none, 1 misaligned, 2 out of range
- `prog_start`  in  1  pulse: begin a load at `prog_base`
- `prog_base`  in  `IDX_W`  first word index to write
- `prog_valid`  in  1  `prog_data` is valid
- `prog_data`  in  `DATA_W`  instruction word to store
- `prog_last`  in  1  qualifies the final word of the load
- `prog_ready`  out  1  a load word can be accepted
- `load_busy`  out  1  high in CLEAR or LOAD
- `load_done`  out  1  one-cycle pulse after the last word is written

## Operation
- FSM states: CLEAR, IDLE, LOAD.
- Reset forces CLEAR.
- **CLEAR:**
  - Writes NOP (`32'h0000_0013`, zero-extended/truncated to `DATA_W`) at `clr_ptr`, one word per cycle, for `clr_ptr` = 0..DEPTH-1.
  - After writing DEPTH-1, transitions to IDLE.
- **IDLE:**
  - `prog_start` moves the FSM to LOAD and sets `wr_ptr` = `prog_base`.
  - `prog_start` is ignored in CLEAR and LOAD.
- **LOAD:**
  - `prog_ready` = 1.
  - A word is accepted when `prog_valid` && `prog_ready`. The accepted `prog_data` is written at `wr_ptr`, then `wr_ptr` increments modulo DEPTH; DEPTH-1 wraps to 0 and writing continues (silent overwrite).
  - An accepted word with `prog_last` = 1 moves the FSM to IDLE. `load_done` pulses in the following cycle.
  - `prog_last` without `prog_valid` has no effect.
- **Fetch** (evaluated only in IDLE, when `fetch_en` = 1):
  - `pc[1:0]` ≠ 0 → cause 1.
  - Else `pc >> 2` ≥ DEPTH → cause 2.
  - Else `instr_out` ← `mem[pc[IDX_W+1:2]]`, cause 0.
  - On any fault, `instr_out` ← NOP and `instr_valid` = 1. Misaligned takes priority over out of range.
- **Fetch while stalled:**
  - `fetch_en` = 0 in IDLE → `instr_valid` = 0; `instr_out` and `fetch_fault` hold.
  - `fetch_en` = 1 in CLEAR or LOAD → `instr_valid` = 0; `instr_out` holds. No read or write conflict exists by construction.
- **Reset mid-LOAD or mid-CLEAR:** abandon the operation, restart CLEAR from index 0, and drop any partial load.

## Timing
- Reset values:
  - `instr_out` = NOP
  - `instr_valid` = 0
  - `fetch_fault` = 0
  - `prog_ready` = 0
  - `load_busy` = 1
  - `load_done` = 0
- Fetch latency: 1 cycle. `pc` is sampled at edge N; `instr_out`, `instr_valid` and `fetch_fault` are valid after edge N.
- CLEAR duration: exactly DEPTH cycles after reset deasserts. The first IDLE cycle is reset-release + DEPTH.
- LOAD throughput: 1 word/cycle. `prog_ready` is a registered function of state only.
- `load_busy` falls in the same cycle `load_done` rises.
- Back-to-back fetches supported every cycle.

## Structure
- Package `imem_pkg` holds:
  - `IMEM_NOP` constant
  - `imem_state_e` {CLEAR, IDLE, LOAD}
  - `fetch_fault_e` {FAULT_NONE, FAULT_MISALIGN, FAULT_RANGE}
- Sub-module `imem_array`: `DEPTH`×`DATA_W` storage with one synchronous write port and one registered read port, with no reset on the storage. The clear sweep replaces the per-entry reset loop.
- Top-level logic: FSM, pointer muxing, and fault decode.

## Test plan
- Reset, DEPTH=64, then wait → `load_busy` high for 64 cycles. Fetch at pc=0x0 and pc=0xFC → `instr_out` = 0x00000013, `instr_valid` = 1, fault 0.
- Load `prog_base`=2 with words 0x00500093, 0x00108113 (`last` on 2nd) → `load_done` pulse. Fetch pc=0x8 → 0x00500093; pc=0xC → 0x00108113; pc=0x10 → NOP.
- Fetch pc=0x6 → fault 1, NOP. Fetch pc=0x100 (DEPTH=64) → fault 2, NOP. Fetch pc=0x102 → fault 1.
- `prog_base`=63, 3 words A, B, C → `mem[63]`=A, `mem[0]`=B, `mem[1]`=C. Then `prog_valid` toggled with gaps → no extra writes.
- Reset asserted after 1 of 4 LOAD words → CLEAR restarts. After DEPTH cycles, all entries read NOP and `load_done` never pulses.
- `fetch_en` held high throughout a LOAD → `instr_valid` = 0 every LOAD cycle. The first IDLE cycle returns valid data one cycle later.
